logic_unit_seq: RTL and testbench

LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

---
 rtl/logic_unit_seq_pkg.sv | 24 ++
 rtl/lus_chunk_step.sv | 36 +++
 rtl/logic_unit_seq.sv | 146 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_seq_pkg.sv
// Shared definitions for logic_unit_seq: opcode constants and FSM state encoding.
package logic_unit_seq_pkg;

  localparam logic [3:0] OpZero   = 4'b0000;
  localparam logic [3:0] OpAnd    = 4'b0001;
  localparam logic [3:0] OpOr     = 4'b0010;
  localparam logic [3:0] OpXor    = 4'b0011;
  localparam logic [3:0] OpSext16 = 4'b0100;
  localparam logic [3:0] OpSext8  = 4'b0101;
  localparam logic [3:0] OpZext16 = 4'b0110;
  localparam logic [3:0] OpZext8  = 4'b0111;
  localparam logic [3:0] OpNor    = 4'b1000;
  localparam logic [3:0] OpAndn   = 4'b1001;
  localparam logic [3:0] OpBrev   = 4'b1010;
  localparam logic [3:0] OpClz    = 4'b1011;
  localparam logic [3:0] OpPopcnt = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/lus_chunk_step.sv
// One chunk of an iterative count: popcount adds the chunk's ones, CLZ adds the
// chunk's leading zeros until the first one has been seen (MSB-first walk).
module lus_chunk_step #(
  parameter int unsigned STEP_BITS = 8,
  parameter int unsigned CNT_W     = 6
) (
  input  logic [STEP_BITS-1:0] chunk,
  input  logic [CNT_W-1:0]     acc,
  input  logic                 seen,
  input  logic                 mode_clz,
  output logic [CNT_W-1:0]     count,
  output logic                 one_seen
);

  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] lz;
  logic             hit;

  // Per-chunk ones count and leading-zero count, then fold into the accumulator.
  always_comb begin
    pop = '0;
    lz  = '0;
    hit = 1'b0;
    for (int i = STEP_BITS - 1; i >= 0; i--) begin
      pop = pop + CNT_W'(chunk[i]);
      if (!hit) begin
        if (chunk[i]) hit = 1'b1;
        else          lz  = lz + CNT_W'(1);
      end
    end
    one_seen = seen | hit;
    if (mode_clz) count = seen ? acc : acc + lz;
    else          count = acc + pop;
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Sequential logic unit: single-cycle bitwise/extend/reverse ops plus optional
// iterative CLZ and popcount. Define LOGIC_UNIT_SEQ_ITER_EN to build the
// iterative engine; otherwise CLZ/popcount return 0 in one cycle.
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] simple_res;

  // Single-cycle result for every opcode that does not need the iterative engine.
  always_comb begin
    simple_res = '0;
    case (opcode)
      OpAnd:    simple_res = operandA & operandB;
      OpOr:     simple_res = operandA | operandB;
      OpXor:    simple_res = operandA ^ operandB;
      OpSext16: simple_res = {{(WIDTH-16){operandA[15]}}, operandA[15:0]};
      OpSext8:  simple_res = {{(WIDTH-8){operandA[7]}}, operandA[7:0]};
      OpZext16: simple_res = {{(WIDTH-16){1'b0}}, operandA[15:0]};
      OpZext8:  simple_res = {{(WIDTH-8){1'b0}}, operandA[7:0]};
      OpNor:    simple_res = ~(operandA | operandB);
      OpAndn:   simple_res = operandA & ~operandB;
      OpBrev: begin
        for (int i = 0; i < int'(WIDTH / 8); i++) begin
          simple_res[8*i +: 8] = operandA[WIDTH-8-8*i +: 8];
        end
      end
      OpClz, OpPopcnt: simple_res = '0;
      default:  simple_res = '0;
    endcase
  end

`ifdef LOGIC_UNIT_SEQ_ITER_EN
  localparam int unsigned NumChunks = WIDTH / STEP_BITS;
  localparam int unsigned CntW      = $clog2(NumChunks + 1);
  localparam int unsigned AccW      = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [AccW-1:0]  acc_q;
  logic [AccW-1:0]  acc_next;
  logic             seen_q;
  logic             seen_next;
  logic             is_clz_q;
  logic [WIDTH-1:0] shift_q;

  lus_chunk_step #(
    .STEP_BITS(STEP_BITS),
    .CNT_W    (AccW)
  ) u_chunk_step (
    .chunk   (shift_q[WIDTH-1 -: STEP_BITS]),
    .acc     (acc_q),
    .seen    (seen_q),
    .mode_clz(is_clz_q),
    .count   (acc_next),
    .one_seen(seen_next)
  );

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  // Control FSM with registered busy/done/result; accumulator stays internal until DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef LOGIC_UNIT_SEQ_ITER_EN
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      seen_q   <= 1'b0;
      is_clz_q <= 1'b0;
      shift_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
`ifdef LOGIC_UNIT_SEQ_ITER_EN
            if (opcode == OpClz || opcode == OpPopcnt) begin
              state_q  <= StRun;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              cnt_q    <= CntW'(NumChunks);
              acc_q    <= '0;
              seen_q   <= 1'b0;
              is_clz_q <= (opcode == OpClz);
              shift_q  <= operandA;
            end else
`endif
            begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= simple_res;
            end
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
`ifdef LOGIC_UNIT_SEQ_ITER_EN
        // Starts are ignored here; fixed chunk count, no early exit.
        StRun: begin
          acc_q   <= acc_next;
          seen_q  <= seen_next;
          shift_q <= shift_q << STEP_BITS;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {{(WIDTH-AccW){1'b0}}, acc_next};
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq (WIDTH=32, STEP_BITS=8). Iterative
// scenarios are selected by LOGIC_UNIT_SEQ_ITER_EN, matching the DUT build.
module tb_logic_unit_seq;
  import logic_unit_seq_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  always #5 clock = ~clock;

  logic_unit_seq #(
    .WIDTH    (W),
    .STEP_BITS(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .operandA(operandA),
    .operandB(operandB),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Present a request for one edge and record the expected result.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    start    = 1'b1;
    opcode   = op;
    operandA = a;
    operandB = b;
    exp_q.push_back(exp);
    @(negedge clock);
  endtask

  // Bounded wait for done; lat counts cycles after the start edge, -1 on timeout.
  task automatic wait_done(input int max_cycles, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < max_cycles) begin
      @(negedge clock);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; opcode = OpAnd; operandA = '1; operandB = '1;
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b, expected 0", done);
    end
    tests_run++;
    if (result !== '0) begin
      tests_failed++; $display("FAIL reset_result: got %h, expected 0", result);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_logic_ops;
    logic [3:0]   ops [5] = '{OpAnd, OpOr, OpAndn, OpZero, 4'hE};
    logic [W-1:0] as  [5] = '{32'hF0F0_1234, 32'h1234_5678, 32'hFFFF_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF};
    logic [W-1:0] bs  [5] = '{32'h0FF0_FFFF, 32'h8765_4321, 32'h0F0F_0F0F, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF};
    logic [W-1:0] ex  [5] = '{32'h00F0_1234, 32'h9775_5779, 32'hF0F0_0000, 32'h0, 32'h0};
    logic [W-1:0] exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], ex[i]);
      start = 1'b0;
      wait_done(3, lat);
      exp = exp_q.pop_front();
      tests_run++;
      if (lat != 1 || result !== exp) begin
        tests_failed++;
        $display("FAIL logic_op%0d: got result=%h latency=%0d, expected result=%h latency=1",
                 i, result, lat, exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp;
    drive(OpXor, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    exp = exp_q.pop_front();
    tests_run++;
    if (done !== 1'b1 || result !== exp) begin
      tests_failed++;
      $display("FAIL b2b_xor: got done=%b result=%h, expected done=1 result=%h", done, result, exp);
    end
    drive(OpNor, 32'hF0F0_1234, 32'h0F0F_0000, 32'h0000_EDCB);
    exp = exp_q.pop_front();
    tests_run++;
    if (done !== 1'b1 || result !== exp) begin
      tests_failed++;
      $display("FAIL b2b_nor: got done=%b result=%h, expected done=1 result=%h", done, result, exp);
    end
    start = 1'b0;
    @(negedge clock);
    tests_run++;
    if (done !== 1'b0 || result !== 32'h0000_EDCB) begin
      tests_failed++;
      $display("FAIL b2b_hold: got done=%b result=%h, expected done=0 result=0000edcb",
               done, result);
    end
  endtask

  task automatic test_extend_reverse;
    logic [3:0]   ops [5] = '{OpSext8, OpZext16, OpBrev, OpSext16, OpZext8};
    logic [W-1:0] as  [5] = '{32'h0000_0080, 32'hABCD_8001, 32'h1122_3344, 32'h0000_8001,
                              32'hABCD_EF12};
    logic [W-1:0] ex  [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h4433_2211, 32'hFFFF_8001,
                              32'h0000_0012};
    logic [W-1:0] exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], 32'h5A5A_5A5A, ex[i]);
      start = 1'b0;
      wait_done(3, lat);
      exp = exp_q.pop_front();
      tests_run++;
      if (lat != 1 || result !== exp) begin
        tests_failed++;
        $display("FAIL ext_rev%0d: got result=%h latency=%0d, expected result=%h latency=1",
                 i, result, lat, exp);
      end
      @(negedge clock);
    end
  endtask

`ifdef LOGIC_UNIT_SEQ_ITER_EN
  task automatic test_clz;
    logic [W-1:0] as [3] = '{32'h0000_0000, 32'h0001_0000, 32'h8000_0000};
    logic [W-1:0] ex [3] = '{32'd32, 32'd15, 32'd0};
    logic [W-1:0] exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      drive(OpClz, as[i], '0, ex[i]);
      start = 1'b0;
      wait_done(10, lat);
      exp = exp_q.pop_front();
      tests_run++;
      if (lat != 5 || result !== exp) begin
        tests_failed++;
        $display("FAIL clz%0d: got result=%0d latency=%0d, expected result=%0d latency=5",
                 i, result, lat, exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_popcount;
    logic [W-1:0] exp;
    drive(OpPopcnt, 32'hFFFF_0001, '0, 32'd17);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL pop_run_c%0d: got busy=%b done=%b, expected busy=1 done=0", c, busy, done);
      end
      if (c == 2) begin
        start = 1'b1; opcode = OpXor; operandA = 32'h1234_5678; operandB = 32'hFFFF_FFFF;
      end
      if (c == 3) start = 1'b0;
      @(negedge clock);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b1 || result !== exp) begin
      tests_failed++;
      $display("FAIL pop_done: got busy=%b done=%b result=%0d, expected busy=0 done=1 result=%0d",
               busy, done, result, exp);
    end
    @(negedge clock);
    tests_run++;
    if (done !== 1'b0 || result !== 32'd17) begin
      tests_failed++;
      $display("FAIL pop_hold: got done=%b result=%0d, expected done=0 result=17", done, result);
    end
  endtask

  task automatic test_reset_abort;
    logic late_done = 1'b0;
    drive(OpPopcnt, 32'hFFFF_0001, '0, 32'd17);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    void'(exp_q.pop_front());
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b done=%b result=%h, expected 0 0 00000000",
               busy, done, result);
    end
    repeat (8) begin
      @(negedge clock);
      if (done === 1'b1) late_done = 1'b1;
    end
    tests_run++;
    if (late_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got late done=%b, expected 0", late_done);
    end
  endtask
`else
  task automatic test_no_iter;
    logic [3:0]   ops [2] = '{OpPopcnt, OpClz};
    logic [W-1:0] exp;
    logic         saw_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(ops[i], 32'hFFFF_FFFF, '0, 32'h0);
      start = 1'b0;
      if (busy === 1'b1) saw_busy = 1'b1;
      exp = exp_q.pop_front();
      tests_run++;
      if (done !== 1'b1 || result !== exp) begin
        tests_failed++;
        $display("FAIL noiter%0d: got done=%b result=%h, expected done=1 result=%h",
                 i, done, result, exp);
      end
      repeat (3) begin
        @(negedge clock);
        if (busy === 1'b1) saw_busy = 1'b1;
      end
      // Reload a nonzero result so the next zero result is observable.
      drive(OpOr, 32'h0000_00FF, '0, 32'h0000_00FF);
      start = 1'b0;
      void'(exp_q.pop_front());
      @(negedge clock);
    end
    tests_run++;
    if (saw_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL noiter_busy: got busy seen=%b, expected 0", saw_busy);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; operandA = '0; operandB = '0;
    test_reset();
    test_logic_ops();
    test_back_to_back();
    test_extend_reverse();
`ifdef LOGIC_UNIT_SEQ_ITER_EN
    test_clz();
    test_popcount();
    test_reset_abort();
`else
    test_no_iter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
